// File: rtl/vote_sequencer.sv
// Purpose : sequences one ballot at a time (arm -> select -> cast -> release) into saturating per-candidate tallies.
// Latency : input rise -> registered edge one cycle later -> state/output change the cycle after; cast rise -> vote_done in 2 cycles.
// Backpressure: none; inputs are debounced levels. Edges that arrive in a state that does not use them are dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (synchronous release expected)
//   ballot_en             officer arm level; a rising edge in IDLE opens one ballot
//   cand_btn[N_CAND]      candidate buttons, 1 = pressed
//   cast_btn              cast button, 1 = pressed
//   armed / sel_valid     ballot open (ARMED or SELECTED) / candidate selected (SELECTED or COMMIT)
//   sel_idx               selected candidate, 0 when nothing is selected
//   vote_done, err_multi  single-cycle pulses: vote committed / several candidate edges in one cycle
//   tally, total          saturating counters; candidate i at tally[i*CNT_W +: CNT_W]
module vote_sequencer #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8,
    parameter int SEL_TO = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ballot_en,
    input  logic [N_CAND-1:0]         cand_btn,
    input  logic                      cast_btn,
    output logic                      armed,
    output logic                      sel_valid,
    output logic [2:0]                sel_idx,
    output logic                      vote_done,
    output logic                      err_multi,
    output logic [N_CAND*CNT_W-1:0]   tally,
    output logic [CNT_W+2:0]          total
);

    localparam int TMR_W = $clog2(SEL_TO);
    localparam int TOT_W = CNT_W + 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_SELECTED = 3'd2,
        S_COMMIT   = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t             state_q;
    logic               warm_q;
    logic               ben_s1_q, ben_s2_q;
    logic               cast_s1_q, cast_s2_q;
    logic [N_CAND-1:0]  cand_s1_q, cand_s2_q;
    logic [TMR_W-1:0]   timer_q;
    logic               armed_q, sel_valid_q, vote_done_q, err_multi_q;
    logic [2:0]         sel_idx_q;
    logic [CNT_W-1:0]   tally_q [N_CAND];
    logic [TOT_W-1:0]   total_q;

    // Edge decode from the registered input copies.
    logic               ben_rise, cast_rise;
    logic [N_CAND-1:0]  cand_rise;
    logic [3:0]         rise_cnt;
    logic [2:0]         rise_idx;

    always_comb begin
        ben_rise  = ben_s1_q & ~ben_s2_q;
        cast_rise = cast_s1_q & ~cast_s2_q;
        cand_rise = cand_s1_q & ~cand_s2_q;
        rise_cnt  = 4'd0;
        rise_idx  = 3'd0;
        // rise_idx is only consumed when exactly one edge is present.
        for (int i = N_CAND - 1; i >= 0; i--) begin
            if (cand_rise[i]) begin
                rise_cnt = rise_cnt + 4'd1;
                rise_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            warm_q      <= 1'b0;
            ben_s1_q    <= 1'b0;
            ben_s2_q    <= 1'b0;
            cast_s1_q   <= 1'b0;
            cast_s2_q   <= 1'b0;
            cand_s1_q   <= '0;
            cand_s2_q   <= '0;
            timer_q     <= '0;
            armed_q     <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_idx_q   <= 3'd0;
            vote_done_q <= 1'b0;
            err_multi_q <= 1'b0;
            total_q     <= '0;
            for (int i = 0; i < N_CAND; i++) begin
                tally_q[i] <= '0;
            end
        end else begin
            // First cycle after reset loads both stages from the pins so a
            // button held through reset does not look like a fresh press.
            warm_q    <= 1'b1;
            ben_s1_q  <= ballot_en;
            cast_s1_q <= cast_btn;
            cand_s1_q <= cand_btn;
            if (warm_q) begin
                ben_s2_q  <= ben_s1_q;
                cast_s2_q <= cast_s1_q;
                cand_s2_q <= cand_s1_q;
            end else begin
                ben_s2_q  <= ballot_en;
                cast_s2_q <= cast_btn;
                cand_s2_q <= cand_btn;
            end

            vote_done_q <= 1'b0;
            err_multi_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (ben_rise) begin
                        state_q <= S_ARMED;
                        armed_q <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (rise_cnt == 4'd1) begin
                        state_q     <= S_SELECTED;
                        sel_valid_q <= 1'b1;
                        sel_idx_q   <= rise_idx;
                        timer_q     <= '0;
                    end else if (rise_cnt > 4'd1) begin
                        err_multi_q <= 1'b1;
                    end
                end
                S_SELECTED: begin
                    // Cast outranks any candidate edge in the same cycle.
                    if (cast_rise) begin
                        state_q     <= S_COMMIT;
                        armed_q     <= 1'b0;
                        vote_done_q <= 1'b1;
                    end else begin
                        if (rise_cnt > 4'd1) begin
                            err_multi_q <= 1'b1;
                        end
                        if (rise_cnt == 4'd1) begin
                            sel_idx_q <= rise_idx;
                            timer_q   <= '0;
                        end else if (timer_q == TMR_W'(SEL_TO - 1)) begin
                            state_q     <= S_ARMED;
                            sel_valid_q <= 1'b0;
                            sel_idx_q   <= 3'd0;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < N_CAND; i++) begin
                        if (sel_idx_q == 3'(i) && tally_q[i] != '1) begin
                            tally_q[i] <= tally_q[i] + CNT_W'(1);
                        end
                    end
                    if (total_q != '1) begin
                        total_q <= total_q + TOT_W'(1);
                    end
                    sel_valid_q <= 1'b0;
                    sel_idx_q   <= 3'd0;
                    state_q     <= S_LOCKOUT;
                end
                S_LOCKOUT: begin
                    // Raw pins: everything must be released together before re-arming.
                    if (!ballot_en && !cast_btn && cand_btn == '0) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    armed_q     <= 1'b0;
                    sel_valid_q <= 1'b0;
                    sel_idx_q   <= 3'd0;
                end
            endcase
        end
    end

    assign armed     = armed_q;
    assign sel_valid = sel_valid_q;
    assign sel_idx   = sel_idx_q;
    assign vote_done = vote_done_q;
    assign err_multi = err_multi_q;
    assign total     = total_q;

    for (genvar g = 0; g < N_CAND; g++) begin : g_tally
        assign tally[g*CNT_W +: CNT_W] = tally_q[g];
    end

endmodule

// File: tb/tb_vote_sequencer.sv
module tb_vote_sequencer;
    localparam int N_CAND = 4;
    localparam int CNT_W  = 2;
    localparam int SEL_TO = 8;
    localparam int TOT_W  = CNT_W + 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    ballot_en = 1'b0;
    logic                    cast_btn = 1'b0;
    logic [N_CAND-1:0]       cand_btn = '0;
    logic                    armed, sel_valid, vote_done, err_multi;
    logic [2:0]              sel_idx;
    logic [N_CAND*CNT_W-1:0] tally;
    logic [TOT_W-1:0]        total;

    int compared = 0;
    int mismatched = 0;
    int done_seen = 0;
    int err_seen = 0;

    // Reference model: ballot described as booleans plus an age counter.
    bit                m_open, m_has_sel, m_commit, m_lock, m_done, m_err, m_warm;
    int                m_sel, m_age, m_total;
    int                m_tally [N_CAND];
    bit                m_b1, m_b2, m_k1, m_k2;
    logic [N_CAND-1:0] m_c1, m_c2;

    vote_sequencer #(.N_CAND(N_CAND), .CNT_W(CNT_W), .SEL_TO(SEL_TO)) dut (
        .clk(clk), .rst_n(rst_n), .ballot_en(ballot_en), .cand_btn(cand_btn),
        .cast_btn(cast_btn), .armed(armed), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .vote_done(vote_done), .err_multi(err_multi), .tally(tally), .total(total)
    );

    always #5 clk = ~clk;

    function automatic int dut_tally(int i);
        return int'(tally[i*CNT_W +: CNT_W]);
    endfunction

    task automatic model_reset();
        m_open = 0; m_has_sel = 0; m_commit = 0; m_lock = 0; m_done = 0; m_err = 0; m_warm = 0;
        m_sel = 0; m_age = 0; m_total = 0;
        for (int i = 0; i < N_CAND; i++) m_tally[i] = 0;
        m_b1 = 0; m_b2 = 0; m_k1 = 0; m_k2 = 0; m_c1 = '0; m_c2 = '0;
    endtask

    task automatic model_step();
        bit rb, rk;
        logic [N_CAND-1:0] rc;
        int nr, ni;
        rb = m_b1 && !m_b2;
        rk = m_k1 && !m_k2;
        rc = m_c1 & ~m_c2;
        nr = 0; ni = 0;
        for (int i = 0; i < N_CAND; i++) if (rc[i]) begin nr++; ni = i; end
        m_done = 0; m_err = 0;
        if (m_commit) begin
            if (m_tally[m_sel] < (1 << CNT_W) - 1) m_tally[m_sel]++;
            if (m_total < (1 << TOT_W) - 1) m_total++;
            m_commit = 0; m_has_sel = 0; m_sel = 0; m_lock = 1;
        end else if (m_lock) begin
            if (!ballot_en && !cast_btn && cand_btn == '0) m_lock = 0;
        end else if (!m_open) begin
            if (rb) m_open = 1;
        end else if (!m_has_sel) begin
            if (nr == 1) begin m_has_sel = 1; m_sel = ni; m_age = 0; end
            else if (nr > 1) m_err = 1;
        end else if (rk) begin
            m_open = 0; m_commit = 1; m_done = 1;
        end else begin
            if (nr > 1) m_err = 1;
            if (nr == 1) begin m_sel = ni; m_age = 0; end
            else if (m_age == SEL_TO - 1) begin m_has_sel = 0; m_sel = 0; end
            else m_age++;
        end
        if (m_warm) begin m_b2 = m_b1; m_c2 = m_c1; m_k2 = m_k1; end
        else begin m_b2 = ballot_en; m_c2 = cand_btn; m_k2 = cast_btn; end
        m_b1 = ballot_en; m_c1 = cand_btn; m_k1 = cast_btn; m_warm = 1;
    endtask

    // Advance n clocks; returns just after a falling edge.
    task automatic cyc(int n = 1);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (vote_done) done_seen++;
            if (err_multi) err_seen++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic release_all();
        ballot_en = 1'b0; cast_btn = 1'b0; cand_btn = '0;
    endtask

    task automatic cast_vote(int idx);
        ballot_en = 1'b1; cyc(2);
        cand_btn = N_CAND'(1 << idx); cyc(2);
        cast_btn = 1'b1; cyc(3);
        release_all(); cyc(2);
    endtask

    task automatic test_reset();
        #2;
        compared++; if (armed !== 1'b0) begin mismatched++; $display("FAIL rst_armed: got %b want 0", armed); end
        compared++; if (sel_valid !== 1'b0) begin mismatched++; $display("FAIL rst_sel_valid: got %b want 0", sel_valid); end
        compared++; if (sel_idx !== 3'd0) begin mismatched++; $display("FAIL rst_sel_idx: got %0d want 0", sel_idx); end
        compared++; if (vote_done !== 1'b0 || err_multi !== 1'b0) begin mismatched++; $display("FAIL rst_pulses: got %b%b want 00", vote_done, err_multi); end
        compared++; if (tally !== '0) begin mismatched++; $display("FAIL rst_tally: got %h want 0", tally); end
        compared++; if (total !== '0) begin mismatched++; $display("FAIL rst_total: got %0d want 0", total); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(2);
    endtask

    task automatic test_single_vote();
        int d0;
        d0 = done_seen;
        ballot_en = 1'b1; cyc(1);
        compared++; if (armed !== 1'b0) begin mismatched++; $display("FAIL t1_arm_early: got %b want 0", armed); end
        cyc(1);
        compared++; if (armed !== 1'b1) begin mismatched++; $display("FAIL t1_armed: got %b want 1", armed); end
        cand_btn = 4'b0100; cyc(2);
        compared++; if (sel_valid !== 1'b1 || sel_idx !== 3'd2) begin mismatched++; $display("FAIL t1_sel: got v=%b idx=%0d want v=1 idx=2", sel_valid, sel_idx); end
        cast_btn = 1'b1; cyc(1);
        compared++; if (vote_done !== 1'b0) begin mismatched++; $display("FAIL t1_done_early: got %b want 0", vote_done); end
        cyc(1);
        compared++; if (vote_done !== 1'b1 || armed !== 1'b0 || sel_valid !== 1'b1) begin mismatched++; $display("FAIL t1_commit: got done=%b armed=%b v=%b want 1 0 1", vote_done, armed, sel_valid); end
        cyc(1);
        compared++; if (vote_done !== 1'b0 || sel_valid !== 1'b0) begin mismatched++; $display("FAIL t1_after: got done=%b v=%b want 0 0", vote_done, sel_valid); end
        compared++; if (dut_tally(2) !== 1 || total !== TOT_W'(1)) begin mismatched++; $display("FAIL t1_count: got tally2=%0d total=%0d want 1 1", dut_tally(2), total); end
        release_all(); cyc(2);
        compared++; if (done_seen - d0 !== 1) begin mismatched++; $display("FAIL t1_done_count: got %0d want 1", done_seen - d0); end
    endtask

    task automatic test_change_mind();
        ballot_en = 1'b1; cyc(2);
        cand_btn = 4'b0010; cyc(2);
        compared++; if (sel_idx !== 3'd1) begin mismatched++; $display("FAIL t2_first: got %0d want 1", sel_idx); end
        cand_btn = 4'b0000; cyc(1);
        cand_btn = 4'b1000; cyc(2);
        compared++; if (sel_idx !== 3'd3) begin mismatched++; $display("FAIL t2_second: got %0d want 3", sel_idx); end
        cast_btn = 1'b1; cyc(3);
        release_all(); cyc(2);
        compared++; if (dut_tally(3) !== 1 || dut_tally(1) !== 0 || total !== TOT_W'(2)) begin mismatched++; $display("FAIL t2_tally: got t3=%0d t1=%0d total=%0d want 1 0 2", dut_tally(3), dut_tally(1), total); end
    endtask

    task automatic test_multi_press();
        int e0;
        ballot_en = 1'b1; cyc(2);
        e0 = err_seen;
        cand_btn = 4'b0011; cyc(2);
        compared++; if (err_multi !== 1'b1 || armed !== 1'b1 || sel_valid !== 1'b0) begin mismatched++; $display("FAIL t3_err: got err=%b armed=%b v=%b want 1 1 0", err_multi, armed, sel_valid); end
        cyc(1);
        compared++; if (err_multi !== 1'b0 || err_seen - e0 !== 1) begin mismatched++; $display("FAIL t3_pulse: got err=%b count=%0d want 0 1", err_multi, err_seen - e0); end
        compared++; if (total !== TOT_W'(2)) begin mismatched++; $display("FAIL t3_total: got %0d want 2", total); end
        cand_btn = 4'b0000; cyc(2);
    endtask

    // Continues with the ballot left open by the multi-press scenario.
    task automatic test_timeout();
        int d0;
        cand_btn = 4'b0001; cyc(2);
        compared++; if (sel_valid !== 1'b1 || sel_idx !== 3'd0) begin mismatched++; $display("FAIL t4_sel: got v=%b idx=%0d want 1 0", sel_valid, sel_idx); end
        cyc(SEL_TO - 1);
        compared++; if (sel_valid !== 1'b1) begin mismatched++; $display("FAIL t4_before_to: got %b want 1", sel_valid); end
        cyc(1);
        compared++; if (sel_valid !== 1'b0 || armed !== 1'b1 || sel_idx !== 3'd0) begin mismatched++; $display("FAIL t4_to: got v=%b armed=%b idx=%0d want 0 1 0", sel_valid, armed, sel_idx); end
        d0 = done_seen;
        cast_btn = 1'b1; cyc(3);
        compared++; if (done_seen != d0 || armed !== 1'b1 || total !== TOT_W'(2)) begin mismatched++; $display("FAIL t4_nosel_cast: got votes=%0d armed=%b total=%0d want 0 1 2", done_seen - d0, armed, total); end
        cast_btn = 1'b0; cyc(1);
    endtask

    task automatic test_lockout();
        int d0;
        d0 = done_seen;
        cand_btn = 4'b0100; cyc(2);
        cast_btn = 1'b1; cyc(3);
        compared++; if (done_seen - d0 !== 1) begin mismatched++; $display("FAIL t5_vote: got %0d want 1", done_seen - d0); end
        cand_btn = '0; cast_btn = 1'b0; cyc(3);
        cast_btn = 1'b1; cyc(3);
        cast_btn = 1'b0; cyc(3);
        compared++; if (done_seen - d0 !== 1 || armed !== 1'b0) begin mismatched++; $display("FAIL t5_locked: got votes=%0d armed=%b want 1 0", done_seen - d0, armed); end
        ballot_en = 1'b0; cyc(1);
        ballot_en = 1'b1; cyc(2);
        compared++; if (armed !== 1'b1) begin mismatched++; $display("FAIL t5_rearm: got %b want 1", armed); end
        compared++; if (dut_tally(2) !== 2 || total !== TOT_W'(3)) begin mismatched++; $display("FAIL t5_tally: got t2=%0d total=%0d want 2 3", dut_tally(2), total); end
    endtask

    task automatic test_saturation_reset();
        int d0;
        release_all();
        apply_reset();
        cyc(2);
        d0 = done_seen;
        for (int v = 0; v < 4; v++) cast_vote(0);
        compared++; if (dut_tally(0) !== 3 || total !== TOT_W'(4)) begin mismatched++; $display("FAIL t6_sat: got t0=%0d total=%0d want 3 4", dut_tally(0), total); end
        compared++; if (done_seen - d0 !== 4) begin mismatched++; $display("FAIL t6_done: got %0d want 4", done_seen - d0); end
        ballot_en = 1'b1; cyc(2);
        cand_btn = 4'b0010; cyc(2);
        compared++; if (sel_valid !== 1'b1 || sel_idx !== 3'd1) begin mismatched++; $display("FAIL t6_presel: got v=%b idx=%0d want 1 1", sel_valid, sel_idx); end
        #2 rst_n = 1'b0;
        #1;
        compared++; if (armed !== 1'b0 || sel_valid !== 1'b0 || sel_idx !== 3'd0) begin mismatched++; $display("FAIL t6_rst_state: got armed=%b v=%b idx=%0d want 0 0 0", armed, sel_valid, sel_idx); end
        compared++; if (tally !== '0 || total !== '0) begin mismatched++; $display("FAIL t6_rst_counts: got tally=%h total=%0d want 0 0", tally, total); end
        @(negedge clk);
        release_all();
        rst_n = 1'b1;
        model_reset();
        cyc(2);
    endtask

    task automatic test_held_reset();
        ballot_en = 1'b1; cand_btn = 4'b0001;
        apply_reset();
        cyc(4);
        compared++; if (armed !== 1'b0) begin mismatched++; $display("FAIL held_no_arm: got %b want 0", armed); end
        release_all(); cyc(2);
        ballot_en = 1'b1; cyc(2);
        compared++; if (armed !== 1'b1) begin mismatched++; $display("FAIL held_rearm: got %b want 1", armed); end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) == 0) ballot_en = ~ballot_en;
            if ($urandom_range(5) == 0) cast_btn = ~cast_btn;
            if ($urandom_range(4) == 0) begin
                r = $urandom_range(99);
                if (r < 50) cand_btn = '0;
                else if (r < 85) cand_btn = N_CAND'(1 << $urandom_range(N_CAND - 1));
                else cand_btn = N_CAND'($urandom);
            end
            cyc(1);
            compared++; if (armed !== m_open) begin mismatched++; $display("FAIL rnd_armed c=%0d: got %b want %b", c, armed, m_open); end
            compared++; if (sel_valid !== m_has_sel) begin mismatched++; $display("FAIL rnd_sel_valid c=%0d: got %b want %b", c, sel_valid, m_has_sel); end
            compared++; if (sel_idx !== 3'(m_sel)) begin mismatched++; $display("FAIL rnd_sel_idx c=%0d: got %0d want %0d", c, sel_idx, m_sel); end
            compared++; if (vote_done !== m_done || err_multi !== m_err) begin mismatched++; $display("FAIL rnd_pulses c=%0d: got done=%b err=%b want %b %b", c, vote_done, err_multi, m_done, m_err); end
            compared++; if (total !== TOT_W'(m_total)) begin mismatched++; $display("FAIL rnd_total c=%0d: got %0d want %0d", c, total, m_total); end
            for (int i = 0; i < N_CAND; i++) begin
                compared++; if (dut_tally(i) !== m_tally[i]) begin mismatched++; $display("FAIL rnd_tally%0d c=%0d: got %0d want %0d", i, c, dut_tally(i), m_tally[i]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_vote();
        test_change_mind();
        test_multi_press();
        test_timeout();
        test_lockout();
        test_saturation_reset();
        test_held_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
